// File: rtl/sycy_cipher_pkg.sv
// Shared widths, chaining-mode constants and FSM encoding for the block-mode
// decryption engine and its helpers.
package sycy_cipher_pkg;

    localparam int DEF_BLOCK_W = 64;
    localparam int DEF_KEY_W   = 128;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/chain_delay_line.sv
// Side pipeline that carries {valid, last, chain} alongside the cipher core so
// the CBC xor operand and framing bits reach the output with their block.
module chain_delay_line #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv_i,
    input  logic         valid_i,
    input  logic         last_i,
    input  logic [W-1:0] chain_i,
    output logic         valid_o,
    output logic         last_o,
    output logic [W-1:0] chain_o
);

    logic [DEPTH-1:0]        valid_q;
    logic [DEPTH-1:0]        last_q;
    logic [DEPTH-1:0][W-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
            chain_q <= '0;
        end else if (adv_i) begin
            valid_q[0] <= valid_i;
            last_q[0]  <= last_i;
            chain_q[0] <= chain_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign last_o  = last_q[DEPTH-1];
    assign chain_o = chain_q[DEPTH-1];

endmodule

// File: rtl/full_sync_decryptor.sv
// Fixed-latency pipelined decryption core: LAT enabled cycles from data_i to data_o.
// Round function is the whitening transform D(x) = x ^ key[BLOCK_W-1:0]; production rounds drop in behind this interface.
module full_sync_decryptor #(
    parameter int BLOCK_W = 64,
    parameter int KEY_W   = 128,
    parameter int LAT     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o
);

    logic [LAT-1:0][BLOCK_W-1:0] stage_q;
    // Upper key half is reserved for the full key schedule.
    logic unused_key_hi;

    assign unused_key_hi = ^key_i[KEY_W-1:BLOCK_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q[0] <= data_i ^ key_i[BLOCK_W-1:0];
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[LAT-1];

endmodule

// File: rtl/block_mode_decryptor.sv
// ECB/CBC multi-block decryption engine wrapping a pipelined core; one message per start/done.
// Handshakes: a block moves when valid & ready are both high at a clock edge with ena high; valid never depends on ready.
module block_mode_decryptor
    import sycy_cipher_pkg::*;
#(
    parameter int BLOCK_W  = DEF_BLOCK_W,
    parameter int KEY_W    = DEF_KEY_W,
    parameter int CORE_LAT = 8,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               start,
    input  logic               mode,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   blk_cnt
);

    state_e               state_q, state_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 mode_q, mode_d;
    logic [BLOCK_W-1:0]   chain_q, chain_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 advance, xfer_in, xfer_out, start_acc;
    logic                 tail_valid, tail_last;
    logic [BLOCK_W-1:0]   tail_chain, core_out;

    // Core and side pipeline share one advance so a stall freezes both in lockstep.
    assign advance   = ena & (~tail_valid | out_ready);
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = advance & tail_valid;
    assign start_acc = ena & start & (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                IDLE:    if (start)                state_d = RUN;
                RUN:     if (xfer_in && in_last)   state_d = DRAIN;
                DRAIN:   if (xfer_out && tail_last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == RUN) || (state_q == DRAIN);
        done     = (state_q == DONE);
        in_ready = (state_q == RUN) && advance;
    end

    always_comb begin
        key_d   = key_q;
        mode_d  = mode_q;
        chain_d = chain_q;
        cnt_d   = cnt_q;
        if (start_acc) begin
            key_d   = key;
            mode_d  = mode;
            chain_d = iv;
            cnt_d   = '0;
        end else begin
            if (xfer_in)  chain_d = in_block;
            if (xfer_out) cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= '0;
            mode_q  <= MODE_ECB;
            chain_q <= '0;
            cnt_q   <= '0;
        end else begin
            key_q   <= key_d;
            mode_q  <= mode_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
        end
    end

    full_sync_decryptor #(
        .BLOCK_W (BLOCK_W),
        .KEY_W   (KEY_W),
        .LAT     (CORE_LAT)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .en_i   (advance),
        .key_i  (key_q),
        .data_i (in_block),
        .data_o (core_out)
    );

    chain_delay_line #(
        .DEPTH (CORE_LAT),
        .W     (BLOCK_W)
    ) u_chain (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (advance),
        .valid_i (xfer_in),
        .last_i  (xfer_in & in_last),
        .chain_i (chain_q),
        .valid_o (tail_valid),
        .last_o  (tail_last),
        .chain_o (tail_chain)
    );

    assign out_valid = tail_valid;
    assign out_last  = tail_valid & tail_last;
    assign out_block = !tail_valid         ? '0 :
                       (mode_q == MODE_CBC) ? (core_out ^ tail_chain) : core_out;
    assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_block_mode_decryptor.sv
// Randomized bench for block_mode_decryptor: message-level ECB/CBC model feeding an expected queue.
// Covers directed test-plan messages, backpressure, gaps/ena stalls, mid-run start/key changes and reset mid-message.
module tb_block_mode_decryptor;

    localparam int BW  = 64;
    localparam int KW  = 128;
    localparam int LAT = 8;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst, ena, start, mode;
    logic [KW-1:0] key;
    logic [BW-1:0] iv, in_block;
    logic          in_valid, in_last, out_ready;
    logic          in_ready, out_valid, out_last, busy, done;
    logic [BW-1:0] out_block;
    logic [CW-1:0] blk_cnt;

    block_mode_decryptor #(
        .BLOCK_W (BW),
        .KEY_W   (KW),
        .CORE_LAT(LAT),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .mode      (mode),
        .key       (key),
        .iv        (iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .blk_cnt   (blk_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d required finish earlier", cyc);
        $fatal(1, "global timeout");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [BW:0] got, input logic [BW:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    logic [BW:0]   exp_q[$];
    logic [BW-1:0] msg_q[$];
    int            out_seen = 0;
    int            t_out_first = 0;
    int            t_out_last = 0;
    logic          hold_pend = 1'b0;
    logic [BW:0]   hold_val;
    logic [BW:0]   exp_item;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check_eq("stall_hold_out", {out_last, out_block}, hold_val);
                check_eq("stall_hold_valid", (BW+1)'(out_valid), (BW+1)'(1));
            end
            hold_pend = out_valid && !(out_ready && ena);
            hold_val  = {out_last, out_block};
            if (out_valid && !out_ready)
                check_eq("stall_in_ready", (BW+1)'(in_ready), (BW+1)'(0));
            if (out_valid && out_ready && ena) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", (BW+1)'(out_valid), (BW+1)'(0));
                end else begin
                    exp_item = exp_q.pop_front();
                    check_eq("out_block_last", {out_last, out_block}, exp_item);
                end
                check_eq("blk_cnt_run", (BW+1)'(blk_cnt), (BW+1)'(CW'(out_seen)));
                if (out_seen == 0) t_out_first = cyc;
                t_out_last = cyc;
                out_seen++;
            end
        end
    end

    // ---------------- stall drivers ----------------
    logic rand_rdy = 1'b0;
    logic rand_ena = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        if (rand_ena) ena = ($urandom_range(0, 4) != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic m, input logic [KW-1:0] k, input logic [BW-1:0] v);
        int w;
        mode  = m;
        key   = k;
        iv    = v;
        start = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(ena && !busy && !done) && w < 200);
        check_eq("start_window", (BW+1)'(busy), (BW+1)'(0));
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: the running message must keep the latched values.
        key  = {$urandom, $urandom, $urandom, $urandom};
        iv   = {$urandom, $urandom};
        mode = ~m;
        @(negedge clk);
        check_eq("busy_after_start", (BW+1)'(busy), (BW+1)'(1));
        check_eq("blk_cnt_cleared", (BW+1)'(blk_cnt), (BW+1)'(0));
        @(posedge clk); #1;
    endtask

    task automatic send_block(input logic [BW-1:0] b, input logic last, output int t_acc);
        int w;
        in_valid = 1'b1;
        in_block = b;
        in_last  = last;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready && w < 1000);
        if (!in_ready) check_eq("accept_timeout", (BW+1)'(in_ready), (BW+1)'(1));
        t_acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Message-level reference: ECB p = D(c); CBC p = D(c) ^ previous ciphertext (iv first).
    task automatic run_msg(input logic m, input logic [KW-1:0] k, input logic [BW-1:0] v,
                           input int gap_pct, input bit lat_chk, input bit mid_start);
        logic [BW-1:0] prev, p;
        int n, t_acc, t_acc_first, t_done, w;
        logic ena_at_done;
        n = msg_q.size();
        prev = v;
        for (int i = 0; i < n; i++) begin
            p = msg_q[i] ^ k[BW-1:0];
            if (m) p = p ^ prev;
            prev = msg_q[i];
            exp_q.push_back({(i == n - 1), p});
        end
        out_seen = 0;
        t_acc_first = 0;
        do_start(m, k, v);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                @(posedge clk); #1;
            end
            send_block(msg_q[i], (i == n - 1), t_acc);
            if (i == 0) t_acc_first = t_acc;
            if (mid_start && i == 0 && n > 1) begin
                start = 1'b1;
                key   = ~k;
                iv    = ~v;
                mode  = ~m;
                @(negedge clk);
                check_eq("start_ignored_busy", (BW+1)'(busy), (BW+1)'(1));
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        w = 0;
        while (!done && w < 2000) begin
            @(negedge clk);
            w++;
        end
        t_done = cyc;
        ena_at_done = ena;
        check_eq("done_seen", (BW+1)'(done), (BW+1)'(1));
        check_eq("busy_at_done", (BW+1)'(busy), (BW+1)'(0));
        check_eq("done_after_last", (BW+1)'(t_done - t_out_last), (BW+1)'(1));
        check_eq("blk_cnt_final", (BW+1)'(blk_cnt), (BW+1)'(CW'(n)));
        check_eq("exp_q_drained", (BW+1)'(exp_q.size()), (BW+1)'(0));
        if (lat_chk)
            check_eq("first_latency", (BW+1)'(t_out_first - t_acc_first), (BW+1)'(LAT));
        @(negedge clk);
        if (ena_at_done) check_eq("done_one_cycle", (BW+1)'(done), (BW+1)'(0));
        @(posedge clk); #1;
        msg_q.delete();
    endtask

    task automatic quiet_stalls();
        rand_rdy  = 1'b0;
        rand_ena  = 1'b0;
        @(posedge clk); #2;
        ena       = 1'b1;
        out_ready = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t_tmp, done_hits;
        rst = 1'b1; ena = 1'b1; start = 1'b0; mode = 1'b0;
        key = '0; iv = '0; in_valid = 1'b0; in_block = '0; in_last = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready",  (BW+1)'(in_ready),  (BW+1)'(0));
        check_eq("rst_out_valid", (BW+1)'(out_valid), (BW+1)'(0));
        check_eq("rst_out_last",  (BW+1)'(out_last),  (BW+1)'(0));
        check_eq("rst_busy",      (BW+1)'(busy),      (BW+1)'(0));
        check_eq("rst_done",      (BW+1)'(done),      (BW+1)'(0));
        check_eq("rst_out_block", (BW+1)'(out_block), (BW+1)'(0));
        check_eq("rst_blk_cnt",   (BW+1)'(blk_cnt),   (BW+1)'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ECB streaming, four blocks back to back
        for (int i = 1; i <= 4; i++) msg_q.push_back(BW'(i));
        run_msg(1'b0, {64'h0, 64'h0F0F_0F0F_0F0F_0F0F}, '0, 0, 1'b1, 1'b0);

        // CBC with known iv, zero key
        msg_q.push_back(64'h1);
        msg_q.push_back(64'h2);
        run_msg(1'b1, '0, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1'b1, 1'b0);

        // Backpressure window of five cycles while output is valid
        for (int i = 0; i < 6; i++) msg_q.push_back({$urandom, $urandom});
        fork
            run_msg(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 1'b0);
            begin
                int w;
                w = 0;
                while (!out_valid && w < 500) begin
                    @(negedge clk);
                    w++;
                end
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // Gaps on the input and ena dropping mid-stream, CBC
        rand_ena = 1'b1;
        for (int i = 0; i < 8; i++) msg_q.push_back({$urandom, $urandom});
        run_msg(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 35, 1'b0, 1'b0);
        quiet_stalls();

        // start while busy plus key/iv/mode changes mid-run
        for (int i = 0; i < 5; i++) msg_q.push_back({$urandom, $urandom});
        run_msg(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 1'b1);

        // Reset after two of five blocks, with start asserted alongside rst
        do_start(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        send_block({$urandom, $urandom}, 1'b0, t_tmp);
        send_block({$urandom, $urandom}, 1'b0, t_tmp);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("rst_mid_busy",      (BW+1)'(busy),      (BW+1)'(0));
        check_eq("rst_mid_out_valid", (BW+1)'(out_valid), (BW+1)'(0));
        check_eq("rst_mid_blk_cnt",   (BW+1)'(blk_cnt),   (BW+1)'(0));
        check_eq("rst_mid_in_ready",  (BW+1)'(in_ready),  (BW+1)'(0));
        done_hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || out_valid) done_hits++;
        end
        check_eq("rst_mid_no_done", (BW+1)'(done_hits), (BW+1)'(0));
        @(posedge clk); #1;
        msg_q.push_back({$urandom, $urandom});
        run_msg(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 0, 1'b1, 1'b0);

        // Randomized messages with random backpressure, gaps and ena
        rand_rdy = 1'b1;
        rand_ena = 1'b1;
        for (int m = 0; m < 10; m++) begin
            int len;
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) msg_q.push_back({$urandom, $urandom});
            run_msg(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom}, 25, 1'b0, (m % 3) == 0);
        end
        quiet_stalls();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
